// File: rtl/regfile_write_queue.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_write_queue
//  Purpose  : In-order writeback FIFO in front of the register-file write
//             port, with youngest-entry read forwarding for two read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_write_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_rd,
   input  logic [XLEN-1:0]            in_data,
   input  logic                       wr_stall,
   output logic                       rd_we,
   output logic [4:0]                 rd_addr,
   output logic [XLEN-1:0]            rd_data,
   input  logic [4:0]                 rs1_addr,
   input  logic [4:0]                 rs2_addr,
   output logic                       fwd1_hit,
   output logic [XLEN-1:0]            fwd1_data,
   output logic                       fwd2_hit,
   output logic [XLEN-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;

   logic [4:0]          r_rd    [DEPTH];
   logic [XLEN-1:0]     r_data  [DEPTH];
   logic [DEPTH-1:0]    r_valid;
   logic [c_PTR_W-1:0]  r_head;
   logic [c_PTR_W-1:0]  r_tail;
   logic [c_CNT_W-1:0]  r_count;

   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic [c_PTR_W-1:0]  w_age_idx [DEPTH];

   assign w_full   = (r_count == c_CNT_W'(DEPTH));
   assign empty    = (r_count == '0);
   assign in_ready = !w_full;
   // x0 requests still handshake but never occupy an entry
   assign w_push   = in_valid && !w_full && (in_rd != 5'd0);
   assign w_pop    = !empty && !wr_stall;

   assign rd_we    = w_pop;
   assign rd_addr  = empty ? 5'd0 : r_rd[r_head];
   assign rd_data  = empty ? '0   : r_data[r_head];
   assign count    = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[r_tail]   <= in_rd;
         r_data[r_tail] <= in_data;
      end
   end

   // Slot index of the k-th oldest entry; scanning k upward leaves the youngest match
   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      assign w_age_idx[k] = r_head + c_PTR_W'(k);
   end

   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (r_valid[w_age_idx[k]]) begin
            if ((rs1_addr != 5'd0) && (r_rd[w_age_idx[k]] == rs1_addr)) begin
               fwd1_hit  = 1'b1;
               fwd1_data = r_data[w_age_idx[k]];
            end
            if ((rs2_addr != 5'd0) && (r_rd[w_age_idx[k]] == rs2_addr)) begin
               fwd2_hit  = 1'b1;
               fwd2_data = r_data[w_age_idx[k]];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side buffer that sits in front of the 32-entry register file's single synchronous write port. Functional units push writeback requests (destination register plus data) through a valid/ready handshake. The block holds them in an in-order FIFO and retires one per cycle onto the write port whenever the port is not stalled. It also snoops both register-file read addresses and forwards the youngest queued value, so readers never see stale data while writes are pending.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- XLEN, 32, data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a writeback request.
- in_ready  out  1  queue can accept; equals !full.
- in_rd  in  5  destination register of the request.
- in_data  in  XLEN  writeback data.
- wr_stall  in  1  write port unavailable this cycle; head is held.
- rd_we  out  1  write enable to the register file.
- rd_addr  out  5  register-file write address.
- rd_data  out  XLEN  register-file write data.
- rs1_addr  in  5  snooped read address, port 1.
- rs2_addr  in  5  snooped read address, port 2.
- fwd1_hit  out  1  queued value exists for rs1_addr.
- fwd1_data  out  XLEN  youngest queued value for rs1_addr.
- fwd2_hit  out  1  queued value exists for rs2_addr.
- fwd2_data  out  XLEN  youngest queued value for rs2_addr.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH entries of {rd[4:0], data[XLEN-1:0], valid}, plus head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Push (accept): in_valid && in_ready at a rising edge.
  - If in_rd != 0, store the entry at tail, advance tail, count +1.
  - If in_rd == 0, complete the handshake but store nothing (x0 writes are discarded).
- Pop: !empty && !wr_stall at a rising edge. Advance head and count -1; the register file commits the same entry on that edge.
- Write port, combinational from the head entry:
  - rd_we = !empty && !wr_stall.
  - rd_addr and rd_data = head entry fields.
  - When empty, rd_addr = 0 and rd_data = 0.
- Simultaneous push and pop: both take effect and count is unchanged.
- When full, in_ready = 0 even if a pop occurs that cycle (no same-cycle pass-through).
- Forwarding, combinational:
  - For each read port, compare the address against all valid entries.
  - fwdN_hit = any match with address != 0.
  - fwdN_data = data of the youngest matching entry (closest to tail); 0 when there is no hit.
  - The incoming in_* request is not searched; only stored entries are.
- The head entry stays a forwarding candidate through its pop edge. After that edge the register file itself holds the value.
- Ordering: retirement is strictly FIFO. Multiple entries for the same rd retire oldest first, so the final register value is the youngest write.

## Timing
- Reset (asynchronous on rst=1): head=0, tail=0, count=0, all entry valid bits cleared. Pending writes are discarded, never written.
- Output values during and after reset:
  - empty=1, in_ready=1, rd_we=0.
  - rd_addr=0, rd_data=0.
  - fwd1_hit=fwd2_hit=0, fwd*_data=0, count=0.
- Latency, empty queue:
  - A push at edge N makes rd_we=1 during cycle N+1.
  - The register file commits at edge N+1, provided wr_stall=0.
- Throughput: one push and one pop per cycle sustained; count stays constant.
- wr_stall=1 holds rd_we=0 and head unchanged. Pushes continue until full.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Reset asserted mid-operation: the queue clears immediately and no partial write is issued. rd_we drops asynchronously.

## Test plan
- Reset, then push x1=11111111, x2=22222222, x3=33333333 on consecutive cycles with wr_stall=0 -> rd_we pulses one cycle each, rd_addr 1,2,3 in order, count never exceeds 1.
- wr_stall=1, push x5..x8 (data 5,6,7,8) -> after 4 pushes count=4 and in_ready=0. A 5th push is refused. Release the stall -> writes x5..x8 retire in order on 4 consecutive cycles, empty=1 after the last.
- wr_stall=1, push x4=AAAA0000 then x4=BBBB0000, set rs1_addr=4, rs2_addr=0 -> fwd1_hit=1 with fwd1_data=BBBB0000, fwd2_hit=0. Release the stall -> x4 written AAAA0000 then BBBB0000.
- Push rd=0, data FFFFFFFF -> in_ready handshake completes, count stays 0, rd_we stays 0.
- Stall, fill the queue to 3 entries, assert rst for one cycle mid-stream -> count=0, rd_we=0, no forward hits. The next push x9=99999999 retires alone.
- Run 10 push/pop cycles with a DEPTH=4 wrap -> retired sequence matches the pushed sequence exactly, with no drops or duplicates.
